// File: rtl/scan_pkg.sv
// Shared types and packet constants for the barcode scan transmit scheduler.
package scan_pkg;

    typedef logic [12:0][3:0] bcd13_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_DECIDE,
        S_SEND
    } state_t;

    localparam logic [7:0]  PKT_PREAMBLE = 8'hAA;
    localparam logic [7:0]  PKT_TERM     = 8'h0A;
    localparam int unsigned PKT_LEN      = 16;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return {4'h3, d};
    endfunction

    function automatic logic [7:0] code_xor(input bcd13_t c);
        logic [7:0] x;
        x = '0;
        for (int unsigned i = 0; i < 13; i++) begin
            x = x ^ digit_ascii(c[i]);
        end
        return x;
    endfunction

endpackage

// File: rtl/ean13_check.sv
// Serial EAN-13 checksum engine: one digit per cycle from [12] down to [0].
module ean13_check
    import scan_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    input  bcd13_t code,
    output logic   done,
    output logic   valid
);

    logic       active_q, active_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] sum_q, sum_d;
    logic       bad_q, bad_d;

    logic [3:0] digit;
    logic [7:0] weighted;
    logic [3:0] rem;
    logic [3:0] expect_chk;

    assign digit    = code[idx_q];
    assign weighted = idx_q[0] ? (8'(digit) * 8'd3) : 8'(digit);

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            idx_q    <= '0;
            sum_q    <= '0;
            bad_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            bad_q    <= bad_d;
        end
    end

    always_comb begin
        active_d = active_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        bad_d    = bad_q;
        if (start) begin
            active_d = 1'b1;
            idx_d    = 4'd12;
            sum_d    = '0;
            bad_d    = 1'b0;
        end else if (active_q) begin
            if (digit > 4'd9) begin
                bad_d = 1'b1;
            end
            if (idx_q == 4'd0) begin
                active_d = 1'b0;
            end else begin
                idx_d = idx_q - 4'd1;
                sum_d = sum_q + weighted;
            end
        end
    end

    // On the final cycle sum_q holds digits [12]..[1]; digit is the check digit.
    assign rem        = 4'(sum_q % 8'd10);
    assign expect_chk = (rem == 4'd0) ? 4'd0 : (4'd10 - rem);
    assign done       = active_q && (idx_q == 4'd0);
    assign valid      = done && !bad_q && (digit == expect_chk);

endmodule

// File: rtl/scan_tx_sched.sv
// Confirms a stable valid EAN-13 code over several frames and streams it as a 16-byte UART packet.
module scan_tx_sched
    import scan_pkg::*;
#(
    parameter int unsigned CONFIRM_N     = 3,
    parameter int unsigned REPEAT_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       scan_en,
    input  bcd13_t     scan_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       code_sent,
    output logic [7:0] err_cnt
);

    localparam int unsigned MW = $clog2(CONFIRM_N + 1);
    localparam int unsigned RW = $clog2(REPEAT_FRAMES + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(CONFIRM_N);
    localparam logic [RW-1:0] REP_MAX   = RW'(REPEAT_FRAMES);

    state_t        state_q, state_d;
    bcd13_t        cand_q, cand_d;
    bcd13_t        prev_code_q, prev_code_d;
    bcd13_t        last_sent_q, last_sent_d;
    logic          seen_q, seen_d;
    logic          sent_flag_q, sent_flag_d;
    logic          code_ok_q, code_ok_d;
    logic          code_sent_q, code_sent_d;
    logic [MW-1:0] match_q, match_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [7:0]    err_q, err_d;
    logic [3:0]    byte_q, byte_d;

    logic          chk_start;
    logic          chk_done;
    logic          chk_valid;
    logic [MW-1:0] match_upd;

    ean13_check u_check (
        .clk   (clk),
        .rst   (rst),
        .start (chk_start),
        .code  (cand_q),
        .done  (chk_done),
        .valid (chk_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cand_q      <= '0;
            prev_code_q <= '0;
            last_sent_q <= '0;
            seen_q      <= 1'b0;
            sent_flag_q <= 1'b0;
            code_ok_q   <= 1'b0;
            code_sent_q <= 1'b0;
            match_q     <= '0;
            rep_q       <= '0;
            err_q       <= '0;
            byte_q      <= '0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            prev_code_q <= prev_code_d;
            last_sent_q <= last_sent_d;
            seen_q      <= seen_d;
            sent_flag_q <= sent_flag_d;
            code_ok_q   <= code_ok_d;
            code_sent_q <= code_sent_d;
            match_q     <= match_d;
            rep_q       <= rep_d;
            err_q       <= err_d;
            byte_q      <= byte_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        prev_code_d = prev_code_q;
        last_sent_d = last_sent_q;
        seen_d      = seen_q;
        sent_flag_d = sent_flag_q;
        code_ok_d   = code_ok_q;
        code_sent_d = 1'b0;
        match_d     = match_q;
        rep_d       = rep_q;
        err_d       = err_q;
        byte_d      = byte_q;
        chk_start   = 1'b0;
        match_upd   = match_q;

        if (scan_en) begin
            seen_d = 1'b1;
        end else if (frame_start) begin
            seen_d = 1'b0;
        end

        // cand only follows the scanner while idle and not being handed to the checker
        if (scan_en && (state_q == S_IDLE) && !(frame_start && seen_q)) begin
            cand_d = scan_data;
        end

        if (frame_start && (rep_q != REP_MAX)) begin
            rep_d = rep_q + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    if (seen_q) begin
                        state_d   = S_CHECK;
                        chk_start = 1'b1;
                    end else begin
                        match_d = '0;
                    end
                end
            end
            S_CHECK: begin
                if (chk_done) begin
                    code_ok_d = chk_valid;
                    state_d   = S_DECIDE;
                end
            end
            S_DECIDE: begin
                state_d = S_IDLE;
                if (!code_ok_q) begin
                    if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                    match_d = '0;
                end else begin
                    if (cand_q == prev_code_q) begin
                        match_upd = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
                    end else begin
                        match_upd   = MW'(1);
                        prev_code_d = cand_q;
                    end
                    match_d = match_upd;
                    if ((match_upd == MATCH_MAX) &&
                        ((cand_q != last_sent_q) || (rep_q >= REP_MAX) || !sent_flag_q)) begin
                        state_d = S_SEND;
                        byte_d  = '0;
                    end
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    if (byte_q == 4'(PKT_LEN - 1)) begin
                        state_d     = S_IDLE;
                        code_sent_d = 1'b1;
                        last_sent_d = cand_q;
                        sent_flag_d = 1'b1;
                        rep_d       = '0;
                    end else begin
                        byte_d = byte_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        if (state_q == S_SEND) begin
            case (byte_q)
                4'd0:    tx_data = PKT_PREAMBLE;
                4'd14:   tx_data = code_xor(cand_q);
                4'd15:   tx_data = PKT_TERM;
                default: tx_data = digit_ascii(cand_q[4'(4'd13 - byte_q)]);
            endcase
        end
    end

    assign tx_valid  = (state_q == S_SEND);
    assign busy      = (state_q != S_IDLE);
    assign code_sent = code_sent_q;
    assign err_cnt   = err_q;

endmodule

// File: tb/tb_scan_tx_sched.sv
// Directed bench for scan_tx_sched: confirmation, rejection, repeat timing, backpressure and reset.
module tb_scan_tx_sched;
    import scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_start;
    logic       scan_en;
    bcd13_t     scan_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       code_sent;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    scan_tx_sched #(
        .CONFIRM_N     (3),
        .REPEAT_FRAMES (60)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .scan_en     (scan_en),
        .scan_data   (scan_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .code_sent   (code_sent),
        .err_cnt     (err_cnt)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] acc_q[$];
    int         sent_q[$];
    int         valid_cycles = 0;
    int         stall_viol   = 0;
    int         frame_no     = 0;

    logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
    logic [7:0] pd = '0;

    localparam bcd13_t CODE_A   = 52'h6901234567892;
    localparam bcd13_t CODE_BAD = 52'h6901234567893;
    localparam bcd13_t CODE_B   = 52'h4006381333931;

    logic [7:0] pkt_a[16] = '{8'hAA, 8'h36, 8'h39, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
                              8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h32, 8'h3C, 8'h0A};
    logic [7:0] pkt_b[16] = '{8'hAA, 8'h34, 8'h30, 8'h30, 8'h36, 8'h33, 8'h38, 8'h31,
                              8'h33, 8'h33, 8'h33, 8'h39, 8'h33, 8'h31, 8'h30, 8'h0A};

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid) valid_cycles++;
            if (tx_valid && tx_ready) acc_q.push_back(tx_data);
            if (code_sent) sent_q.push_back(frame_no);
        end
        if (pv && !pr && !prst) begin
            if (!tx_valid || (tx_data !== pd)) stall_viol++;
        end
        pv   = tx_valid;
        pr   = tx_ready;
        pd   = tx_data;
        prst = rst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input bit en, input bcd13_t code, input bit rmode, input int rst_at);
        int n;
        bit did_rst;
        did_rst = 1'b0;
        frame_no++;
        scan_data = code;
        scan_en   = en;
        tick();
        scan_en = 1'b0;
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        n = rmode ? 120 : 40;
        for (int i = 0; i < n; i++) begin
            tx_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((rst_at >= 0) && !did_rst && tx_valid && (acc_q.size() == rst_at)) begin
                rst     = 1'b1;
                did_rst = 1'b1;
                tick();
                chk("rst_drops_tx_valid", {31'd0, tx_valid}, 32'd0);
                chk("rst_clears_busy", {31'd0, busy}, 32'd0);
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        tx_ready = 1'b1;
    endtask

    task automatic chk_packet(input string tag, input logic [7:0] exp[16]);
        chk({tag, "_len"}, acc_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), (i < acc_q.size()) ? {24'd0, acc_q[i]} : 32'hFFFF_FFFF,
                {24'd0, exp[i]});
        end
    endtask

    int vc0, sc0, v0;

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        scan_en     = 1'b0;
        scan_data   = '0;
        tx_ready    = 1'b1;
        repeat (3) tick();
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_code_sent", {31'd0, code_sent}, 32'd0);
        chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b0;
        tick();

        // valid code confirmed over three frames
        acc_q.delete();
        sent_q.delete();
        frame_no = 0;
        vc0 = valid_cycles;
        repeat (3) do_frame(1'b1, CODE_A, 1'b0, -1);
        chk_packet("pktA", pkt_a);
        chk("pktA_sent_count", sent_q.size(), 1);
        chk("pktA_sent_frame", (sent_q.size() > 0) ? sent_q[0] : -1, 3);
        chk("pktA_valid_cycles", valid_cycles - vc0, 16);

        // bad check digit is rejected every frame
        do_frame(1'b0, '0, 1'b0, -1);
        vc0 = valid_cycles;
        repeat (3) do_frame(1'b1, CODE_BAD, 1'b0, -1);
        chk("bad_err_cnt", {24'd0, err_cnt}, 32'd3);
        chk("bad_no_tx", valid_cycles - vc0, 0);

        // a gap frame breaks confirmation
        do_frame(1'b0, '0, 1'b0, -1);
        vc0 = valid_cycles;
        sc0 = sent_q.size();
        do_frame(1'b1, CODE_B, 1'b0, -1);
        do_frame(1'b1, CODE_B, 1'b0, -1);
        do_frame(1'b0, '0, 1'b0, -1);
        do_frame(1'b1, CODE_B, 1'b0, -1);
        do_frame(1'b1, CODE_B, 1'b0, -1);
        chk("gap_no_sent", sent_q.size() - sc0, 0);
        chk("gap_no_tx", valid_cycles - vc0, 0);

        // held code repeats every REPEAT_FRAMES frames
        do_frame(1'b0, '0, 1'b0, -1);
        sent_q.delete();
        frame_no = 0;
        repeat (130) do_frame(1'b1, CODE_B, 1'b0, -1);
        chk("repeat_count", sent_q.size(), 3);
        chk("repeat_frame0", (sent_q.size() > 0) ? sent_q[0] : -1, 3);
        chk("repeat_frame1", (sent_q.size() > 1) ? sent_q[1] : -1, 63);
        chk("repeat_frame2", (sent_q.size() > 2) ? sent_q[2] : -1, 123);

        // random backpressure during a packet
        do_frame(1'b0, '0, 1'b0, -1);
        acc_q.delete();
        sc0 = sent_q.size();
        v0 = stall_viol;
        repeat (3) do_frame(1'b1, CODE_A, 1'b1, -1);
        chk_packet("bp", pkt_a);
        chk("bp_stall_stable", stall_viol - v0, 0);
        chk("bp_sent_count", sent_q.size() - sc0, 1);

        // reset mid-packet, then a fresh full packet
        do_frame(1'b0, '0, 1'b0, -1);
        acc_q.delete();
        do_frame(1'b1, CODE_B, 1'b0, -1);
        do_frame(1'b1, CODE_B, 1'b0, -1);
        do_frame(1'b1, CODE_B, 1'b0, 7);
        chk("rst_partial_len", acc_q.size(), 7);
        chk("rst_err_cleared", {24'd0, err_cnt}, 32'd0);
        acc_q.delete();
        sent_q.delete();
        frame_no = 0;
        repeat (3) do_frame(1'b1, CODE_B, 1'b0, -1);
        chk_packet("after_rst", pkt_b);
        chk("after_rst_sent_frame", (sent_q.size() > 0) ? sent_q[0] : -1, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
